// File: rtl/or_arbiter.sv
// Four-requester round-robin arbiter feeding a one-deep registered OR unit.
// The granted requester's A|B lands in the result register on the next edge.
// The register can be refilled in the same cycle that the consumer drains it.
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | result register empty, any pending request may be granted
// FULL  | result register holds res_data/res_id, res_valid=1
module or_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req_valid,
    input  logic [4*WIDTH-1:0]   req_a,
    input  logic [4*WIDTH-1:0]   req_b,
    output logic [3:0]           req_ready,
    output logic                 res_valid,
    output logic [WIDTH-1:0]     res_data,
    output logic [1:0]           res_id,
    input  logic                 res_ready,
    output logic [15:0]          op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       ptr;
    logic             slot_free;
    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic             grant;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // Reset gates the grant so nothing is accepted while rst_n is low.
    assign slot_free = rst_n && ((state_q == IDLE) || res_ready);
    assign grant     = slot_free && gnt_vld;
    assign res_valid = (state_q == FULL);

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        logic [1:0] cand;
        cand    = ptr;
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + k[1:0];
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // One-hot grant, depends only on valid, state, res_ready and ptr.
    always_comb begin
        req_ready = 4'b0000;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Select the granted requester's operands.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < 4; i++) begin
            if (gnt_idx == i[1:0]) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: a grant always fills the register; a drain without
    // a grant empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant) state_d = FULL;
            FULL: if (res_ready && !grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register, priority pointer and operation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data <= '0;
            res_id   <= 2'd0;
            ptr      <= 2'd0;
            op_count <= 16'd0;
        end else if (grant) begin
            res_data <= op_a | op_b;
            res_id   <= gnt_idx;
            ptr      <= gnt_idx + 2'd1;
            op_count <= op_count + 16'd1;
        end
    end

endmodule
